tridiag_coeff_loader: RTL
=========================

// Module: tridiag_coeff_loader
// PURPOSE
//  Upstream front-end for the tridiagonal determinant engine.
//  - Collects the a/b/c coefficients as single-word writes into register banks.
//  - Presents them to the engine as flattened vectors (element 0 at the LSBs).
//  - Launches a run with a one-cycle start pulse, captures det when the engine raises done,
//    then runs the ack handshake so the engine returns to idle.
//  - Returns the result on a valid/ready port. Coefficients persist, so repeated runs need no reload.
// PARAMETERS
//  N      16   matrix order; 3..16. Must equal the engine's N.
//  WIDTH  16   coefficient width (signed two's complement); result is 2*WIDTH.
//  IDX_W  4    write index width; must be >= $clog2(N).
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset; also drives the engine's reset
//  wr_valid   in   1            coefficient write request
//  wr_ready   out  1            write accepted when wr_valid & wr_ready
//  wr_sel     in   2            0=a, 1=b, 2=c, 3=invalid
//  wr_idx     in   IDX_W        element index
//  wr_data    in   WIDTH        coefficient value
//  wr_err     out  1            1-cycle pulse: accepted write was dropped (bad sel or index)
//  cmd_go     in   1            request a determinant run
//  cmd_clear  in   1            clear the loaded-mask (coefficient data is kept)
//  go_err     out  1            1-cycle pulse: cmd_go was rejected
//  busy       out  1            high in every state except LOAD
//  a_flat     out  WIDTH*(N-1)  a[0..N-2] to the engine
//  b_flat     out  WIDTH*N      b[0..N-1] to the engine
//  c_flat     out  WIDTH*(N-1)  c[0..N-2] to the engine
//  det_start  out  1            engine start, 1-cycle pulse
//  det_ack    out  1            engine ack
//  det_done   in   1            engine done
//  det_in     in   2*WIDTH      engine det
//  res_valid  out  1            result valid
//  res_ready  in   1            result consumed when res_valid & res_ready
//  res_det    out  2*WIDTH      captured determinant (signed)
// BEHAVIOUR
//  Reset
//  - All outputs, coefficient banks, loaded-mask and res_det go to 0; state goes to LOAD.
//  - rst asserted mid-run aborts that run; no result is produced.
//  States: LOAD -> START -> WAIT_DONE -> ACK -> RESULT -> LOAD.
//  LOAD
//  - wr_ready = ~cmd_clear.
//  - Valid write: stores wr_data and sets its loaded-mask bit.
//  - Invalid write is still accepted (handshake completes) but is dropped, and wr_err = 1 on the next cycle.
//    Invalid means: sel=3; sel=a or c with idx>N-2; or sel=b with idx>N-1.
//  - cmd_clear zeroes the mask (3N-2 bits) next cycle.
//  - cmd_go is checked against the registered mask; a write in the same cycle does not count.
//    - Mask full and no cmd_clear: go to START.
//    - Otherwise: go_err pulse, stay in LOAD.
//    - cmd_go together with cmd_clear: clear wins and go_err pulses.
//  START
//  - det_start = 1 for exactly this one cycle (go accepted at T gives det_start at T+1).
//  - Next state is WAIT_DONE.
//  Busy states
//  - wr_ready = 0.
//  - cmd_go pulses go_err; cmd_clear is ignored.
//  WAIT_DONE
//  - On det_done=1: res_det <= det_in, go to ACK. No timeout.
//  ACK
//  - det_ack = 1; hold until det_done is sampled 0, then go to RESULT.
//  - The engine keeps done high for one cycle after ack; this is expected.
//  RESULT
//  - res_valid = 1 with res_det stable.
//  - On res_ready: go to LOAD next cycle and drop res_valid. The mask is kept.
//  Datapath
//  - a/b/c_flat are the bank registers, stable whenever the engine is not idle.
//  - No arithmetic is done in this block.
//  Latency
//  - go to result = 1 (START) + engine run + 1 (capture) + ack cycles.
// TESTING
//  1. N=4. Write b=2,2,2,2 and a=c=1,1,1, then cmd_go:
//     det_start pulses once; later res_valid=1 with res_det=5; det_ack held until det_done=0.
//  2. Load all but c[2], then cmd_go: go_err=1 for one cycle, no det_start.
//     Write c[2], then cmd_go: run starts.
//  3. Drop-write checks, then cmd_go:
//     - wr_sel=3 -> wr_err.
//     - wr_sel=0, idx=3 (N=4) -> wr_err, no bank change.
//     - Same-cycle wr+cmd_clear -> wr_ready=0.
//  4. Hold res_ready=0 for 10 cycles: res_valid and res_det stay stable.
//     Then assert res_ready: next cycle busy=0.
//     A second cmd_go without reloading gives the same det.
//  5. Assert rst during WAIT_DONE: next cycle state=LOAD, all outputs 0, mask empty.
//  6. Negative check: b=-3,-3,-3,-3 with a=c=1 (N=4) -> res_det=55 (sign-extended correctly).
//     cmd_go while busy -> go_err.

Source files
------------

// File: rtl/tridiag_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tridiag_coeff_loader
// Purpose  : Front-end for the tridiagonal determinant engine. Collects the
//            a/b/c coefficients through single-word writes, presents them as
//            flattened vectors (element 0 at the LSBs), launches a run with a
//            one-cycle start pulse, captures det on done, performs the ack
//            handshake and returns the result on a valid/ready port.
//            Coefficients persist across runs; only the loaded-mask is cleared.
// Ports    : clk/rst                    clock, synchronous active-high reset
//            wr_*_i / wr_ready_o        coefficient write channel
//            wr_err_o                   pulse: accepted write was dropped
//            cmd_go_i / cmd_clear_i     run request / clear loaded-mask
//            go_err_o                   pulse: cmd_go rejected
//            busy_o                     high in every state except LOAD
//            a/b/c_flat_o               coefficient banks to the engine
//            det_start_o/det_ack_o      engine start pulse / ack
//            det_done_i/det_in_i        engine done / determinant
//            res_valid_o/res_ready_i    result handshake
//            res_det_o                  captured determinant (signed)
// Revision : 1.0 - initial release
// ============================================================================
module tridiag_coeff_loader #(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [1:0]             wr_sel_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   wr_err_o,
  input  logic                   cmd_go_i,
  input  logic                   cmd_clear_i,
  output logic                   go_err_o,
  output logic                   busy_o,
  output logic [WIDTH*(N-1)-1:0] a_flat_o,
  output logic [WIDTH*N-1:0]     b_flat_o,
  output logic [WIDTH*(N-1)-1:0] c_flat_o,
  output logic                   det_start_o,
  output logic                   det_ack_o,
  input  logic                   det_done_i,
  input  logic [2*WIDTH-1:0]     det_in_i,
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [2*WIDTH-1:0]     res_det_o
);

  localparam logic [2:0] c_LOAD      = 3'd0;
  localparam logic [2:0] c_START     = 3'd1;
  localparam logic [2:0] c_WAIT_DONE = 3'd2;
  localparam logic [2:0] c_ACK       = 3'd3;
  localparam logic [2:0] c_RESULT    = 3'd4;

  // Mask layout: a[i] at bit i, b[i] at bit N-1+i, c[i] at bit 2N-1+i.
  localparam int c_MASK_W = 3*N-2;

  logic [2:0]          state_q, state_d;
  logic [WIDTH-1:0]    a_q [N-1];
  logic [WIDTH-1:0]    b_q [N];
  logic [WIDTH-1:0]    c_q [N-1];
  logic [c_MASK_W-1:0] mask_q, mask_d;
  logic                wr_err_q, go_err_q, go_err_d;
  logic [2*WIDTH-1:0]  res_det_q;

  logic                w_load, w_wr_fire, w_wr_legal, w_go_ok;
  logic [c_MASK_W-1:0] w_wr_bit;

  assign w_load     = (state_q == c_LOAD);
  assign wr_ready_o = w_load & ~cmd_clear_i;
  assign w_wr_fire  = wr_valid_i & wr_ready_o;

  // One-hot target of the write; all-zero for a bad sel or out-of-range index,
  // so legality falls out of the decode itself.
  always_comb begin
    w_wr_bit = '0;
    for (int i = 0; i < N-1; i++) begin
      if (wr_idx_i == IDX_W'(i)) begin
        if (wr_sel_i == 2'd0) w_wr_bit[i]         = 1'b1;
        if (wr_sel_i == 2'd2) w_wr_bit[2*N-1+i]   = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (wr_idx_i == IDX_W'(i) && wr_sel_i == 2'd1) w_wr_bit[N-1+i] = 1'b1;
    end
  end

  assign w_wr_legal = |w_wr_bit;

  // Go is judged on the registered mask only; clear in the same cycle wins.
  assign w_go_ok = w_load & cmd_go_i & ~cmd_clear_i & (&mask_q);

  always_comb begin
    mask_d = mask_q;
    if (w_load && cmd_clear_i) begin
      mask_d = '0;
    end else if (w_wr_fire) begin
      mask_d = mask_q | w_wr_bit;
    end
  end

  always_comb begin
    state_d  = state_q;
    go_err_d = cmd_go_i & ~w_go_ok;
    case (state_q)
      c_LOAD:      if (w_go_ok) state_d = c_START;
      c_START:     state_d = c_WAIT_DONE;
      c_WAIT_DONE: if (det_done_i) state_d = c_ACK;
      // The engine holds done for a cycle after seeing ack; wait it out.
      c_ACK:       if (!det_done_i) state_d = c_RESULT;
      c_RESULT:    if (res_ready_i) state_d = c_LOAD;
      default:     state_d = c_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= c_LOAD;
      mask_q    <= '0;
      wr_err_q  <= 1'b0;
      go_err_q  <= 1'b0;
      res_det_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      wr_err_q <= w_wr_fire & ~w_wr_legal;
      go_err_q <= go_err_d;
      if (state_q == c_WAIT_DONE && det_done_i) res_det_q <= det_in_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N-1; i++) begin
        a_q[i] <= '0;
        c_q[i] <= '0;
      end
      for (int i = 0; i < N; i++) b_q[i] <= '0;
    end else if (w_wr_fire) begin
      for (int i = 0; i < N-1; i++) begin
        if (w_wr_bit[i])       a_q[i] <= wr_data_i;
        if (w_wr_bit[2*N-1+i]) c_q[i] <= wr_data_i;
      end
      for (int i = 0; i < N; i++) begin
        if (w_wr_bit[N-1+i]) b_q[i] <= wr_data_i;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N-1; gi++) begin : g_flat_ac
      assign a_flat_o[gi*WIDTH +: WIDTH] = a_q[gi];
      assign c_flat_o[gi*WIDTH +: WIDTH] = c_q[gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_flat_b
      assign b_flat_o[gi*WIDTH +: WIDTH] = b_q[gi];
    end
  endgenerate

  assign busy_o      = ~w_load;
  assign det_start_o = (state_q == c_START);
  assign det_ack_o   = (state_q == c_ACK);
  assign res_valid_o = (state_q == c_RESULT);
  assign res_det_o   = res_det_q;
  assign wr_err_o    = wr_err_q;
  assign go_err_o    = go_err_q;

endmodule
`default_nettype wire
